// File: rtl/hydra_pkg.sv
// -----------------------------------------------------------------------------
// hydra_pkg
//   Shared definitions for the packet-buffer read path: page address layout
//   (bank index + page within bank), page geometry and the read sequencer
//   state encoding.
// -----------------------------------------------------------------------------
package hydra_pkg;

    localparam int PAGE_ADDR_W    = 16;
    localparam int BANK_W         = 5;
    localparam int PAGE_W         = 11;
    localparam int WORDS_PER_PAGE = 8;
    localparam int WORD_W         = 16;
    localparam int ECC_W          = 8;
    localparam int WCNT_W         = 3;

    // Word counter value of the final word of a page.
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_PAGE - 1);

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [PAGE_W-1:0] page;
    } page_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } rd_state_t;

endpackage : hydra_pkg

// File: rtl/port_read_sequencer.sv
// -----------------------------------------------------------------------------
// port_read_sequencer
//   Per-output-port read controller. Accepts one packet descriptor (head and
//   tail page address), then walks the page chain through the bank jump
//   table, requesting one bank read slot per page from the arbiter and
//   forwarding the 8 returned words of each page with sop/eop/page-last
//   markers and the page ECC code to the egress ECC-check stage.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   pkt_vld/pkt_rdy       descriptor handshake from the port queue
//   pkt_head, pkt_tail    first / last page address of the packet
//   sram_req, sram_sel    read-slot request and bank index to the arbiter
//   sram_gnt              same-cycle grant from the arbiter
//   rd_page_down          page read issued (request granted)
//   rd_page               page number within the bank, valid with sram_req
//   rd_xfer_data_vld/data word stream from the selected bank
//   rd_next_page          jump-table entry, valid one cycle after page_down
//   rd_ecc_code           page ECC code, valid one cycle after page_down
//   out_vld, out_data     word stream to egress
//   out_sop, out_eop      first word of packet / last word of tail page
//   out_ecc               ECC code of the page being output
//   out_page_last         last word of any page (ECC check strobe)
//   busy                  packet in progress
// -----------------------------------------------------------------------------
module port_read_sequencer
    import hydra_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pkt_vld,
    output logic                   pkt_rdy,
    input  logic [PAGE_ADDR_W-1:0] pkt_head,
    input  logic [PAGE_ADDR_W-1:0] pkt_tail,
    output logic                   sram_req,
    output logic [BANK_W-1:0]      sram_sel,
    input  logic                   sram_gnt,
    output logic                   rd_page_down,
    output logic [PAGE_W-1:0]      rd_page,
    input  logic                   rd_xfer_data_vld,
    input  logic [WORD_W-1:0]      rd_xfer_data,
    input  logic [PAGE_ADDR_W-1:0] rd_next_page,
    input  logic [ECC_W-1:0]       rd_ecc_code,
    output logic                   out_vld,
    output logic [WORD_W-1:0]      out_data,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [ECC_W-1:0]       out_ecc,
    output logic                   out_page_last,
    output logic                   busy
);

    rd_state_t          state;
    rd_state_t          state_nxt;
    page_addr_t         cur_page;
    page_addr_t         tail_page;
    logic               first_word;
    logic               last_page;
    logic               cap_pend;
    logic [WCNT_W-1:0]  wcnt;
    logic [ECC_W-1:0]   ecc_q;

    logic               req;
    logic               grant;
    logic               accept;
    logic               word_vld;
    logic               word_last;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and request generation.
    // On the 8th word of a non-tail page the next request is raised in the
    // same cycle, so an immediate grant keeps the word stream gapless; a
    // denied early request falls back to REQ and is held there.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pkt_vld) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                req = 1'b1;
                if (sram_gnt) begin
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (rd_xfer_data_vld && (wcnt == WCNT_LAST)) begin
                    if (last_page) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        req       = 1'b1;
                        state_nxt = sram_gnt ? ST_XFER : ST_REQ;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign grant     = req & sram_gnt;
    assign accept    = pkt_rdy & pkt_vld;
    assign word_vld  = (state == ST_XFER) & rd_xfer_data_vld;
    assign word_last = word_vld & (wcnt == WCNT_LAST);

    // -------------------------------------------------------------------------
    // Page chain, word counter and ECC capture.
    // cap_pend marks the cycle after page_down, the only cycle in which the
    // jump-table entry and ECC code from the bank are valid. The tail page
    // keeps cur_page unchanged so the jump-table entry is never followed
    // past the end of the packet.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_page   <= '0;
            tail_page  <= '0;
            first_word <= 1'b0;
            last_page  <= 1'b0;
            cap_pend   <= 1'b0;
            wcnt       <= '0;
            ecc_q      <= '0;
        end else begin
            if (accept) begin
                cur_page   <= page_addr_t'(pkt_head);
                tail_page  <= page_addr_t'(pkt_tail);
                first_word <= 1'b1;
            end

            if (cap_pend) begin
                ecc_q <= rd_ecc_code;
                if (!last_page) begin
                    cur_page <= page_addr_t'(rd_next_page);
                end
            end

            if (word_vld) begin
                wcnt       <= wcnt + 1'b1;
                first_word <= 1'b0;
            end

            // A grant coinciding with the 8th word restarts the count for
            // the new page.
            cap_pend <= grant;
            if (grant) begin
                wcnt      <= '0;
                last_page <= (cur_page == tail_page);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Bank/page and data are gated so every output reads zero while
    // idle or in reset; pkt_rdy also drops combinationally under reset.
    // out_ecc bypasses the register during the capture cycle so the first
    // word of a page already carries that page's code.
    // -------------------------------------------------------------------------
    assign pkt_rdy       = rst_n & (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign sram_req      = req;
    assign sram_sel      = req ? cur_page.bank : '0;
    assign rd_page       = req ? cur_page.page : '0;
    assign rd_page_down  = grant;
    assign out_vld       = word_vld;
    assign out_data      = word_vld ? rd_xfer_data : '0;
    assign out_sop       = word_vld & first_word;
    assign out_page_last = word_last;
    assign out_eop       = word_last & last_page;
    assign out_ecc       = cap_pend ? rd_ecc_code : ecc_q;

endmodule : port_read_sequencer

// File: tb/tb_port_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_port_read_sequencer
//   Directed bench. A bank model answers each page_down with the jump-table
//   entry and ECC code (valid only in the following cycle) and 8 words
//   {page[7:0], word index}; ECC is page[7:0] ^ 8'hA5. Words, page_downs and
//   handshake signals are logged per cycle and checked against hand-computed
//   values after each scenario.
// -----------------------------------------------------------------------------
module tb_port_read_sequencer;

    logic        clk;
    logic        rst_n;
    logic        pkt_vld;
    logic        pkt_rdy;
    logic [15:0] pkt_head;
    logic [15:0] pkt_tail;
    logic        sram_req;
    logic [4:0]  sram_sel;
    logic        sram_gnt;
    logic        rd_page_down;
    logic [10:0] rd_page;
    logic        rd_xfer_data_vld;
    logic [15:0] rd_xfer_data;
    logic [15:0] rd_next_page;
    logic [7:0]  rd_ecc_code;
    logic        out_vld;
    logic [15:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [7:0]  out_ecc;
    logic        out_page_last;
    logic        busy;

    port_read_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pkt_vld          (pkt_vld),
        .pkt_rdy          (pkt_rdy),
        .pkt_head         (pkt_head),
        .pkt_tail         (pkt_tail),
        .sram_req         (sram_req),
        .sram_sel         (sram_sel),
        .sram_gnt         (sram_gnt),
        .rd_page_down     (rd_page_down),
        .rd_page          (rd_page),
        .rd_xfer_data_vld (rd_xfer_data_vld),
        .rd_xfer_data     (rd_xfer_data),
        .rd_next_page     (rd_next_page),
        .rd_ecc_code      (rd_ecc_code),
        .out_vld          (out_vld),
        .out_data         (out_data),
        .out_sop          (out_sop),
        .out_eop          (out_eop),
        .out_ecc          (out_ecc),
        .out_page_last    (out_page_last),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // descriptor list offered by the port queue
    logic [15:0] d_head [0:3];
    logic [15:0] d_tail [0:3];
    int          n_desc;
    int          d_idx;

    // jump table (two entries) and grant denial control
    logic [15:0] map_k0, map_v0, map_k1, map_v1;
    logic [15:0] deny_pg;
    int          deny_cnt;

    // bank model
    logic        b_act;
    logic [15:0] b_pg;
    int          b_widx;
    logic        s_pd;
    logic [15:0] s_pg;

    // per-scenario logs
    int          cyc;
    logic        lg_rdy   [0:63];
    logic        lg_req   [0:63];
    logic [15:0] lg_rq_pg [0:63];
    int          nw;
    logic [15:0] w_data [0:63];
    logic [7:0]  w_ecc  [0:63];
    logic        w_sop  [0:63];
    logic        w_eop  [0:63];
    logic        w_pl   [0:63];
    int          w_cyc  [0:63];
    int          npd;
    int          pd_cyc [0:7];
    logic [15:0] pd_pg  [0:7];

    function automatic logic [15:0] next_of(input logic [15:0] pg);
        if (pg == map_k0) return map_v0;
        if (pg == map_k1) return map_v1;
        return 16'hBEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // which: 0 sop, 1 eop, 2 page_last
    function automatic int count_flag(input int which);
        int c = 0;
        for (int i = 0; i < nw; i++) begin
            if (which == 0 && w_sop[i]) c++;
            if (which == 1 && w_eop[i]) c++;
            if (which == 2 && w_pl[i])  c++;
        end
        return c;
    endfunction

    task automatic drive();
        pkt_vld  = (d_idx < n_desc);
        pkt_head = pkt_vld ? d_head[d_idx] : 16'h0;
        pkt_tail = pkt_vld ? d_tail[d_idx] : 16'h0;
        sram_gnt = !(deny_cnt > 0 && {sram_sel, rd_page} == deny_pg);
    endtask

    task automatic sample();
        if (cyc < 64) begin
            lg_rdy[cyc]   = pkt_rdy;
            lg_req[cyc]   = sram_req;
            lg_rq_pg[cyc] = {sram_sel, rd_page};
        end
        if (out_vld && nw < 64) begin
            w_data[nw] = out_data;
            w_ecc[nw]  = out_ecc;
            w_sop[nw]  = out_sop;
            w_eop[nw]  = out_eop;
            w_pl[nw]   = out_page_last;
            w_cyc[nw]  = cyc;
            nw++;
        end
        if (rd_page_down && npd < 8) begin
            pd_cyc[npd] = cyc;
            pd_pg[npd]  = {sram_sel, rd_page};
            npd++;
        end
        s_pd = rd_page_down;
        s_pg = {sram_sel, rd_page};
        if (sram_req && !sram_gnt && deny_cnt > 0) deny_cnt--;
        if (pkt_vld && pkt_rdy) d_idx++;
    endtask

    task automatic advance();
        rd_next_page = 16'hBEEF;
        rd_ecc_code  = 8'hEE;
        if (s_pd) begin
            rd_next_page = next_of(s_pg);
            rd_ecc_code  = s_pg[7:0] ^ 8'hA5;
            b_act  = 1'b1;
            b_pg   = s_pg;
            b_widx = 0;
        end
        if (b_act) begin
            rd_xfer_data_vld = 1'b1;
            rd_xfer_data     = {b_pg[7:0], 8'(b_widx)};
            b_widx++;
            if (b_widx == 8) b_act = 1'b0;
        end else begin
            rd_xfer_data_vld = 1'b0;
            rd_xfer_data     = 16'h5A5A;
        end
    endtask

    // Each cycle: inputs at edge+2, outputs sampled at edge+4, bank model
    // advanced at the next edge+1.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            drive();
            #2;
            sample();
            @(posedge clk);
            #1;
            cyc++;
            advance();
        end
    endtask

    task automatic new_test();
        cyc      = 0;
        nw       = 0;
        npd      = 0;
        d_idx    = 0;
        deny_cnt = 0;
        deny_pg  = 16'hFFFF;
        map_k0   = 16'hFFFF;
        map_k1   = 16'hFFFF;
        map_v0   = 16'h0;
        map_v1   = 16'h0;
        for (int i = 0; i < 64; i++) begin
            lg_rdy[i]   = 1'b0;
            lg_req[i]   = 1'b0;
            lg_rq_pg[i] = 16'h0;
        end
    endtask

    function automatic int data_order_errors(input logic [7:0] first_pg_lsb);
        int bad = 0;
        for (int i = 0; i < nw; i++) begin
            if (w_data[i] !== {8'(first_pg_lsb + 8'(i / 8)), 8'(i % 8)}) bad++;
        end
        return bad;
    endfunction

    initial begin
        int c;
        rst_n = 1'b0;
        pkt_vld = 1'b0; pkt_head = '0; pkt_tail = '0; sram_gnt = 1'b0;
        rd_xfer_data_vld = 1'b0; rd_xfer_data = '0;
        rd_next_page = '0; rd_ecc_code = '0;
        b_act = 1'b0; b_pg = '0; b_widx = 0; s_pd = 1'b0; s_pg = '0;
        n_desc = 0;
        new_test();

        // ---- reset state
        #12;
        chk("rst_pkt_rdy", pkt_rdy, 1'b0);
        chk("rst_ctrl_outs", {out_vld, out_sop, out_eop, out_page_last, busy,
                              sram_req, rd_page_down}, 7'b0);
        chk("rst_data_outs", {out_data, out_ecc, sram_sel, rd_page}, 40'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_pkt_rdy", pkt_rdy, 1'b1);
        @(posedge clk); #1;

        // ---- T1: single page 0x0805
        new_test();
        d_head[0] = 16'h0805; d_tail[0] = 16'h0805; n_desc = 1;
        run(12);
        chk("t1_rdy_c0", lg_rdy[0], 1'b1);
        chk("t1_req_c1", lg_req[1], 1'b1);
        chk("t1_req_sel_page", lg_rq_pg[1], {5'd1, 11'd5});
        chk("t1_npd", npd, 1);
        chk("t1_pd_cyc", pd_cyc[0], 1);
        chk("t1_nwords", nw, 8);
        chk("t1_first_word_cyc", w_cyc[0], 2);
        chk("t1_last_word_cyc", w_cyc[7], 9);
        chk("t1_word0", w_data[0], 16'h0500);
        chk("t1_word7", w_data[7], 16'h0507);
        chk("t1_ecc_w0", w_ecc[0], 8'hA0);
        chk("t1_ecc_w7", w_ecc[7], 8'hA0);
        chk("t1_sop_w0", w_sop[0], 1'b1);
        chk("t1_sop_count", count_flag(0), 1);
        chk("t1_eop_w7", w_eop[7], 1'b1);
        chk("t1_eop_count", count_flag(1), 1);
        chk("t1_pl_w7", w_pl[7], 1'b1);
        chk("t1_rdy_after_eop", lg_rdy[10], 1'b1);
        chk("t1_busy_end", busy, 1'b0);

        // ---- T2: three-page chain 0x0010 -> 0x0011 -> 0x0012
        new_test();
        map_k0 = 16'h0010; map_v0 = 16'h0011;
        map_k1 = 16'h0011; map_v1 = 16'h0012;
        d_head[0] = 16'h0010; d_tail[0] = 16'h0012; n_desc = 1;
        run(28);
        chk("t2_npd", npd, 3);
        chk("t2_pd0", pd_cyc[0], 1);
        chk("t2_pd1", pd_cyc[1], 9);
        chk("t2_pd2", pd_cyc[2], 17);
        chk("t2_pd2_page", pd_pg[2], 16'h0012);
        chk("t2_nwords", nw, 24);
        chk("t2_contiguous", w_cyc[23] - w_cyc[0], 23);
        chk("t2_data_order", data_order_errors(8'h10), 0);
        chk("t2_ecc_p0", w_ecc[0], 8'hB5);
        chk("t2_ecc_p1", w_ecc[8], 8'hB4);
        chk("t2_ecc_p2", w_ecc[16], 8'hB7);
        chk("t2_eop_count", count_flag(1), 1);
        chk("t2_eop_w23", w_eop[23], 1'b1);
        chk("t2_pl_count", count_flag(2), 3);
        chk("t2_sop_count", count_flag(0), 1);

        // ---- T3: cross-bank chain 0x0010 -> 0xF803
        new_test();
        map_k0 = 16'h0010; map_v0 = 16'hF803;
        d_head[0] = 16'h0010; d_tail[0] = 16'hF803; n_desc = 1;
        run(20);
        chk("t3_npd", npd, 2);
        chk("t3_pd1_cyc", pd_cyc[1], 9);
        chk("t3_pd1_sel_page", pd_pg[1], {5'd31, 11'd3});
        chk("t3_nwords", nw, 16);
        chk("t3_word8", w_data[8], 16'h0300);
        chk("t3_ecc_p1", w_ecc[8], 8'hA6);
        chk("t3_eop_count", count_flag(1), 1);
        chk("t3_eop_w15", w_eop[15], 1'b1);

        // ---- T4: grant withheld 5 cycles on the second page
        new_test();
        map_k0 = 16'h0010; map_v0 = 16'h0011;
        deny_pg = 16'h0011; deny_cnt = 5;
        d_head[0] = 16'h0010; d_tail[0] = 16'h0011; n_desc = 1;
        run(25);
        chk("t4_npd", npd, 2);
        chk("t4_pd1_cyc", pd_cyc[1], 14);
        c = 0;
        for (int i = 9; i <= 14; i++) if (lg_req[i] && lg_rq_pg[i] == 16'h0011) c++;
        chk("t4_req_held_stable", c, 6);
        chk("t4_nwords", nw, 16);
        chk("t4_vld_gap", w_cyc[8] - w_cyc[7], 6);
        chk("t4_data_order", data_order_errors(8'h10), 0);
        chk("t4_ecc_p1", w_ecc[8], 8'hB4);
        chk("t4_eop_count", count_flag(1), 1);

        // ---- T5: pkt_vld held through a transfer
        new_test();
        d_head[0] = 16'h0805; d_tail[0] = 16'h0805;
        d_head[1] = 16'h0012; d_tail[1] = 16'h0012; n_desc = 2;
        run(22);
        c = 0;
        for (int i = 1; i <= 9; i++) if (lg_rdy[i]) c++;
        chk("t5_rdy_low_in_pkt", c, 0);
        chk("t5_rdy_after_eop", lg_rdy[10], 1'b1);
        chk("t5_accepts", d_idx, 2);
        chk("t5_npd", npd, 2);
        chk("t5_pd1_cyc", pd_cyc[1], 11);
        chk("t5_pd1_page", pd_pg[1], 16'h0012);
        chk("t5_word8", w_data[8], 16'h1200);
        chk("t5_sop_w8", w_sop[8], 1'b1);
        chk("t5_eop_count", count_flag(1), 2);

        // ---- T6: reset during word 4 of page 2, then a fresh packet
        new_test();
        map_k0 = 16'h0010; map_v0 = 16'h0011;
        d_head[0] = 16'h0010; d_tail[0] = 16'h0011; n_desc = 1;
        run(14);
        chk("t6_npd_before_rst", npd, 2);
        chk("t6_nwords_before_rst", nw, 12);
        #1;
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl_outs", {out_vld, out_sop, out_eop, out_page_last, busy,
                                 pkt_rdy, sram_req, rd_page_down}, 8'b0);
        chk("t6_rst_data_outs", {out_data, out_ecc, sram_sel, rd_page}, 40'h0);
        b_act = 1'b0; s_pd = 1'b0;
        rd_xfer_data_vld = 1'b0; rd_xfer_data = '0;
        n_desc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t6_rdy_after_release", pkt_rdy, 1'b1);
        chk("t6_busy_after_release", busy, 1'b0);
        @(posedge clk); #1;
        new_test();
        d_head[0] = 16'h0805; d_tail[0] = 16'h0805; n_desc = 1;
        run(12);
        chk("t6_new_pd_page", pd_pg[0], 16'h0805);
        chk("t6_new_nwords", nw, 8);
        chk("t6_new_word0", w_data[0], 16'h0500);
        chk("t6_new_word7", w_data[7], 16'h0507);
        chk("t6_new_ecc", w_ecc[3], 8'hA0);
        chk("t6_new_eop_count", count_flag(1), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_port_read_sequencer
